// File: rtl/divisor_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : divisor_arbiter
// Description : Round-robin front end that shares one Divisor datapath among
//               NREQ requesters. Latches the winner's operands, pulses the
//               divider start, waits for the done rising edge (or a watchdog
//               timeout), and returns quotient/remainder/error to the owner.
//               A zero divisor is answered directly without starting the
//               divider.
// Revision    : 1.0 - initial release
// ============================================================================
module divisor_arbiter #(
    parameter int NREQ    = 4,
    parameter int W       = 8,
    parameter int TIMEOUT = 64
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] num_in,
    input  logic [NREQ*W-1:0] den_in,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [W-1:0]      rsp_coc,
    output logic [W-1:0]      rsp_res,
    output logic              rsp_er,
    output logic              busy,
    output logic              div_start,
    output logic [W-1:0]      div_num,
    output logic [W-1:0]      div_den,
    input  logic              div_done,
    input  logic              div_er,
    input  logic [W-1:0]      div_coc,
    input  logic [W-1:0]      div_res
);

    localparam int c_PW = $clog2(NREQ);
    localparam int c_SW = c_PW + 1;
    localparam int c_TW = $clog2(TIMEOUT) + 1;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;
    localparam logic [1:0] c_RESP  = 2'd3;

    // State and registered outputs
    logic [1:0]      r_state;
    logic [c_PW-1:0] r_ptr;
    logic [c_PW-1:0] r_owner;
    logic [c_TW-1:0] r_timer;
    logic            r_done_q;
    logic [NREQ-1:0] r_gnt;
    logic [NREQ-1:0] r_rsp_valid;
    logic [W-1:0]    r_rsp_coc;
    logic [W-1:0]    r_rsp_res;
    logic            r_rsp_er;
    logic            r_busy;
    logic            r_div_start;
    logic [W-1:0]    r_div_num;
    logic [W-1:0]    r_div_den;

    // Next-state values
    logic [1:0]      w_state;
    logic [c_PW-1:0] w_ptr;
    logic [c_PW-1:0] w_owner;
    logic [c_TW-1:0] w_timer;
    logic [NREQ-1:0] w_gnt;
    logic [NREQ-1:0] w_rsp_valid;
    logic [W-1:0]    w_rsp_coc;
    logic [W-1:0]    w_rsp_res;
    logic            w_rsp_er;
    logic            w_busy;
    logic            w_div_start;
    logic [W-1:0]    w_div_num;
    logic [W-1:0]    w_div_den;

    // Arbitration helpers
    logic            w_found;
    logic [c_PW-1:0] w_winner;
    logic [c_SW-1:0] w_sum;
    logic [W-1:0]    w_sel_num;
    logic [W-1:0]    w_sel_den;
    logic            w_done_rise;

    assign gnt       = r_gnt;
    assign rsp_valid = r_rsp_valid;
    assign rsp_coc   = r_rsp_coc;
    assign rsp_res   = r_rsp_res;
    assign rsp_er    = r_rsp_er;
    assign busy      = r_busy;
    assign div_start = r_div_start;
    assign div_num   = r_div_num;
    assign div_den   = r_div_den;

    assign w_done_rise = div_done & ~r_done_q;
    assign w_sel_num   = num_in[int'(w_winner)*W +: W];
    assign w_sel_den   = den_in[int'(w_winner)*W +: W];

    // Round-robin search: first requesting index at or above ptr, wrapping to 0
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_sum    = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_sum = {1'b0, r_ptr} + c_SW'(k);
            if (w_sum >= c_SW'(NREQ)) begin
                w_sum = w_sum - c_SW'(NREQ);
            end
            if (!w_found && req[w_sum[c_PW-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_sum[c_PW-1:0];
            end
        end
    end

    // Next-state and next-output logic; every output is registered, so the
    // value computed here appears on the port one cycle later
    always_comb begin
        w_state     = r_state;
        w_ptr       = r_ptr;
        w_owner     = r_owner;
        w_timer     = r_timer;
        w_gnt       = '0;
        w_rsp_valid = '0;
        w_div_start = 1'b0;
        w_rsp_coc   = r_rsp_coc;
        w_rsp_res   = r_rsp_res;
        w_rsp_er    = r_rsp_er;
        w_div_num   = r_div_num;
        w_div_den   = r_div_den;
        case (r_state)
            c_IDLE: begin
                if (w_found) begin
                    w_owner          = w_winner;
                    w_div_num        = w_sel_num;
                    w_div_den        = w_sel_den;
                    w_gnt[w_winner]  = 1'b1;
                    if (w_sel_den == '0) begin
                        // Divide-by-zero never reaches the divider
                        w_state   = c_RESP;
                        w_rsp_er  = 1'b1;
                        w_rsp_coc = '0;
                        w_rsp_res = '0;
                    end else begin
                        w_state = c_ISSUE;
                    end
                end
            end
            c_ISSUE: begin
                w_div_start = 1'b1;
                w_timer     = '0;
                w_state     = c_WAIT;
            end
            c_WAIT: begin
                if (w_done_rise) begin
                    w_rsp_coc = div_coc;
                    w_rsp_res = div_res;
                    w_rsp_er  = div_er;
                    w_state   = c_RESP;
                end else if (r_timer == c_TW'(TIMEOUT - 1)) begin
                    // Watchdog: release the owner with an all-ones error result
                    w_rsp_er  = 1'b1;
                    w_rsp_coc = '1;
                    w_rsp_res = '1;
                    w_state   = c_RESP;
                end else begin
                    w_timer = r_timer + 1'b1;
                end
            end
            c_RESP: begin
                w_rsp_valid[r_owner] = 1'b1;
                w_ptr   = (r_owner == c_PW'(NREQ - 1)) ? '0 : r_owner + 1'b1;
                w_state = c_IDLE;
            end
            default: begin
                w_state = c_IDLE;
            end
        endcase
        w_busy = (w_state != c_IDLE);
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= c_IDLE;
            r_ptr       <= '0;
            r_owner     <= '0;
            r_timer     <= '0;
            r_done_q    <= 1'b0;
            r_gnt       <= '0;
            r_rsp_valid <= '0;
            r_rsp_coc   <= '0;
            r_rsp_res   <= '0;
            r_rsp_er    <= 1'b0;
            r_busy      <= 1'b0;
            r_div_start <= 1'b0;
            r_div_num   <= '0;
            r_div_den   <= '0;
        end else begin
            r_state     <= w_state;
            r_ptr       <= w_ptr;
            r_owner     <= w_owner;
            r_timer     <= w_timer;
            r_done_q    <= div_done;
            r_gnt       <= w_gnt;
            r_rsp_valid <= w_rsp_valid;
            r_rsp_coc   <= w_rsp_coc;
            r_rsp_res   <= w_rsp_res;
            r_rsp_er    <= w_rsp_er;
            r_busy      <= w_busy;
            r_div_start <= w_div_start;
            r_div_num   <= w_div_num;
            r_div_den   <= w_div_den;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_divisor_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_divisor_arbiter
// Description : Scoreboard bench for divisor_arbiter with a behavioural
//               divider, a round-robin reference and per-requester queues of
//               expected responses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_divisor_arbiter;

    localparam int NREQ    = 4;
    localparam int W       = 8;
    localparam int TIMEOUT = 64;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] num_in;
    logic [NREQ*W-1:0] den_in;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   rsp_valid;
    logic [W-1:0]      rsp_coc;
    logic [W-1:0]      rsp_res;
    logic              rsp_er;
    logic              busy;
    logic              div_start;
    logic [W-1:0]      div_num;
    logic [W-1:0]      div_den;
    logic              div_done;
    logic              div_er;
    logic [W-1:0]      div_coc;
    logic [W-1:0]      div_res;

    divisor_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RST(RST), .req(req), .num_in(num_in), .den_in(den_in),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_coc(rsp_coc), .rsp_res(rsp_res),
        .rsp_er(rsp_er), .busy(busy), .div_start(div_start), .div_num(div_num),
        .div_den(div_den), .div_done(div_done), .div_er(div_er),
        .div_coc(div_coc), .div_res(div_res)
    );

    always #5 CLK = ~CLK;

    // kind: 0 = divider result, 1 = divide-by-zero bypass, 2 = watchdog
    typedef struct packed {
        logic [W-1:0] coc;
        logic [W-1:0] res;
        logic         er;
        logic [1:0]   kind;
    } exp_t;

    exp_t exp_q [NREQ][$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   starts = 0;
    int   exp_starts = 0;
    logic hang = 1'b0;
    int   lat_next = 2;
    int   last_lat = 0;
    int   dm_cnt = 0;

    always @(posedge CLK) cyc <= cyc + 1;
    always @(negedge CLK) lat_next <= int'($urandom_range(8, 2));

    // Behavioural divider: done stays high until the next start, then drops
    // and rises again lat cycles after start was seen; hang suppresses done
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            div_done <= 1'b0;
            div_er   <= 1'b0;
            div_coc  <= '0;
            div_res  <= '0;
            dm_cnt   <= 0;
        end else if (div_start) begin
            div_done <= 1'b0;
            div_er   <= 1'b1;
            div_coc  <= (div_den == 0) ? '1 : div_num / div_den;
            div_res  <= (div_den == 0) ? '1 : div_num % div_den;
            dm_cnt   <= hang ? 0 : lat_next - 1;
            last_lat <= lat_next;
        end else if (dm_cnt > 0) begin
            dm_cnt <= dm_cnt - 1;
            if (dm_cnt == 1) begin
                div_done <= 1'b1;
                div_er   <= 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
        logic [NREQ-1:0] t;
        for (int k = 0; k < NREQ; k++) begin
            t = r >> ((p + k) % NREQ);
            if (t[0]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    // Monitor: grant order against the round-robin reference, responses
    // against the queued expectations, and response latency
    logic [NREQ-1:0] last_req = '0;
    int mptr = 0;
    int owner_m = 0;
    logic outstanding = 1'b0;
    int gnt_cyc [NREQ];

    initial begin : monitor
        exp_t e;
        int   g;
        int   v;
        int   lat;
        forever begin
            @(negedge CLK);
            if (RST) begin
                for (int i = 0; i < NREQ; i++) exp_q[i].delete();
                mptr = 0;
                outstanding = 1'b0;
            end else begin
                if (div_start) starts++;
                if (gnt != '0) begin
                    g = rr_pick(last_req, mptr);
                    check("gnt_onehot", $countones(gnt), 1);
                    check("gnt_winner", gnt, (g < 0) ? 0 : (1 << g));
                    check("gnt_while_outstanding", outstanding, 0);
                    check("busy_at_gnt", busy, 1);
                    outstanding = 1'b1;
                    owner_m = (g < 0) ? 0 : g;
                    gnt_cyc[owner_m] = cyc;
                end
                if (rsp_valid != '0) begin
                    v = 0;
                    for (int i = 0; i < NREQ; i++) if (rsp_valid[i]) v = i;
                    check("rsp_onehot", $countones(rsp_valid), 1);
                    check("rsp_owner", v, owner_m);
                    check("busy_at_rsp", busy, 0);
                    if (exp_q[v].size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL rsp_unexpected: got rsp_valid %0h expected none", rsp_valid);
                    end else begin
                        e = exp_q[v].pop_front();
                        check("rsp_coc", rsp_coc, e.coc);
                        check("rsp_res", rsp_res, e.res);
                        check("rsp_er", rsp_er, e.er);
                        lat = (e.kind == 2'd1) ? 1 : (e.kind == 2'd2) ? TIMEOUT + 2 : last_lat + 3;
                        check("rsp_latency", cyc - gnt_cyc[v], lat);
                    end
                    outstanding = 1'b0;
                    mptr = (v + 1) % NREQ;
                end
            end
            last_req = req;
        end
    end

    // Drive one request (caller is aligned just after a rising edge) and hold
    // it until granted; keep leaves req high for an immediate follow-up
    task automatic request(input int i, input logic [W-1:0] n, input logic [W-1:0] d, input bit keep);
        exp_t e;
        int   waited;
        num_in[i*W +: W] = n;
        den_in[i*W +: W] = d;
        req[i] = 1'b1;
        if (d == 0) begin
            e.coc = '0; e.res = '0; e.er = 1'b1; e.kind = 2'd1;
        end else if (hang) begin
            e.coc = '1; e.res = '1; e.er = 1'b1; e.kind = 2'd2;
        end else begin
            e.coc = n / d; e.res = n % d; e.er = 1'b0; e.kind = 2'd0;
        end
        exp_q[i].push_back(e);
        if (d != 0) exp_starts++;
        waited = 0;
        do begin
            @(negedge CLK);
            waited++;
        end while (!gnt[i] && waited < 3000);
        if (!gnt[i]) begin
            tests++;
            fails++;
            $display("FAIL gnt_timeout: requester %0d got no gnt, expected one", i);
        end
        @(posedge CLK);
        #1;
        if (!keep) req[i] = 1'b0;
    endtask

    task automatic wait_idle();
        int   waited;
        logic empty;
        waited = 0;
        do begin
            @(negedge CLK);
            waited++;
            empty = 1'b1;
            for (int i = 0; i < NREQ; i++) if (exp_q[i].size() != 0) empty = 1'b0;
        end while (!(empty && !busy) && waited < 500);
        if (!(empty && !busy)) begin
            tests++;
            fails++;
            $display("FAIL idle_timeout: got busy %0b with responses pending, expected idle", busy);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic rand_requester(input int i);
        bit          keep;
        logic [W-1:0] n;
        logic [W-1:0] d;
        for (int k = 0; k < 12; k++) begin
            n = W'($urandom_range(255, 0));
            d = ($urandom_range(7, 0) == 0) ? '0 : W'($urandom_range(255, 1));
            keep = (k < 11) && ($urandom_range(1, 0) == 1);
            request(i, n, d, keep);
            if (!keep) begin
                repeat ($urandom_range(6, 0)) begin
                    @(posedge CLK);
                    #1;
                end
            end
        end
    endtask

    initial begin : stimulus
        req    = '0;
        num_in = '0;
        den_in = '0;
        repeat (2) @(posedge CLK);
        #1;
        check("reset_ctrl", {gnt, rsp_valid, rsp_er, busy, div_start}, 0);
        check("reset_data", {rsp_coc, rsp_res, div_num, div_den}, 0);
        RST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;

        request(0, 8'd100, 8'd20, 1'b0);
        wait_idle();
        request(2, 8'd50, 8'd0, 1'b0);
        wait_idle();

        fork
            begin
                request(0, 8'd30, 8'd5, 1'b1);
                request(0, 8'd200, 8'd7, 1'b0);
            end
            request(1, 8'd7, 8'd2, 1'b0);
            request(2, 8'd0, 8'd10, 1'b0);
            request(3, 8'd255, 8'd16, 1'b0);
        join
        wait_idle();

        hang = 1'b1;
        request(1, 8'd77, 8'd3, 1'b0);
        wait_idle();
        hang = 1'b0;
        request(1, 8'd77, 8'd3, 1'b0);
        wait_idle();

        // Asynchronous reset in the middle of a wait
        hang = 1'b1;
        request(2, 8'd9, 8'd4, 1'b0);
        repeat (10) @(posedge CLK);
        @(negedge CLK);
        #2;
        RST = 1'b1;
        #1;
        check("async_rst_ctrl", {gnt, rsp_valid, rsp_er, busy, div_start}, 0);
        check("async_rst_data", {rsp_coc, rsp_res, div_num, div_den}, 0);
        @(negedge CLK);
        @(posedge CLK);
        #1;
        hang = 1'b0;
        RST = 1'b0;
        fork
            request(3, 8'd99, 8'd10, 1'b0);
            request(0, 8'd64, 8'd8, 1'b0);
        join
        wait_idle();

        fork
            begin
                for (int i = 0; i < NREQ; i++) begin
                    automatic int ii = i;
                    fork
                        rand_requester(ii);
                    join_none
                end
                wait fork;
            end
        join
        wait_idle();

        check("div_start_count", starts, exp_starts);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/divisor_arbiter.md
Name: divisor_arbiter

Overview:
Shares one Divisor datapath (start/Num/Den in, done/er/Coc/Res out) between NREQ requesters.
- Round-robin arbitration picks one requester at a time, latches its operands and issues a single start pulse to the divider.
- The arbiter then waits for completion and returns quotient/remainder/error to the owner.
- A watchdog and a divide-by-zero bypass ensure no requester is stranded.

Parameters:
NREQ, 4, number of requesters (2..8)
W, 8, operand/result width; matches Divisor Num/Den/Coc/Res
TIMEOUT, 64, cycles allowed in WAIT before forced error response

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  asynchronous, active-high reset
req  in  NREQ  per-requester request level
num_in  in  NREQ*W  requester i dividend at bits [i*W +: W]
den_in  in  NREQ*W  requester i divisor at bits [i*W +: W]
gnt  out  NREQ  one-hot, 1-cycle pulse: request accepted, operands latched
rsp_valid  out  NREQ  one-hot, 1-cycle pulse: result for that requester on rsp_*
rsp_coc  out  W  quotient for current response
rsp_res  out  W  remainder for current response
rsp_er  out  1  error flag for current response
busy  out  1  high whenever FSM is not IDLE
div_start  out  1  to Divisor start; 1-cycle pulse
div_num  out  W  to Divisor Num; held stable from ISSUE until leaving WAIT
div_den  out  W  to Divisor Den; same stability rule as div_num
div_done  in  1  from Divisor done (treated as level; rising edge is the completion event)
div_er  in  1  from Divisor er
div_coc  in  W  from Divisor Coc
div_res  in  W  from Divisor Res

Behaviour:
- Reset (async, any state): FSM=IDLE; gnt, rsp_valid, rsp_er, div_start, busy = 0; rsp_coc, rsp_res, div_num, div_den = 0; rr pointer = 0 (requester 0 has priority first); timer = 0; done_q = 0. The Divisor shares the same RST.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req bit is set, choose the winner by round-robin: first set bit searching upward from ptr, wrapping at NREQ-1 -> 0.
  - Latch num/den of the winner into div_num/div_den, record owner, pulse gnt[owner] next cycle.
  - If the latched den == 0 go to RESP with rsp_er=1, rsp_coc=0, rsp_res=0; the divider is not started. Otherwise go to ISSUE.
- ISSUE: div_start=1 for exactly this cycle; timer cleared; go to WAIT.
- WAIT:
  - done_rise = div_done & ~done_q (done_q registered every cycle).
  - On done_rise: capture div_coc, div_er, div_res into rsp_*, then go to RESP.
  - Else if timer == TIMEOUT-1: rsp_er=1, rsp_coc=all-ones, rsp_res=all-ones, go to RESP.
  - Else timer++ (width ceil(log2(TIMEOUT))+1).
- RESP: rsp_valid[owner]=1 for this cycle; ptr = owner+1 mod NREQ; go to IDLE.
- rsp_coc/rsp_res/rsp_er hold their values until the next RESP.
- Latency: req sampled in IDLE -> gnt 1 cycle later. Normal response = divider latency + 3 cycles after gnt. den=0 response = 1 cycle after gnt.
- Handshake:
  - Requesters hold req and operands stable until gnt, then may drop req. Operand changes after gnt are ignored.
  - req held after its rsp_valid is a new request and competes under round-robin.
  - req withdrawn before gnt is dropped with no effect.
- div_done high in IDLE/ISSUE, or already high when entering WAIT without a rising edge, is ignored. Only a rising edge inside WAIT completes the operation.
- Simultaneous requests: exactly one gnt per transaction. The back-to-back minimum is 1 idle cycle between RESP and the next gnt.
- Two requests can never be outstanding at the divider at once. busy=1 from the cycle after the winner is selected through RESP.

Test Plan:
- Single req[0], num=100, den=20 -> gnt[0] 1 cycle later, one div_start pulse, rsp_valid[0] with coc=5, res=0, er=0.
- req[2], num=50, den=0 -> gnt[2], no div_start, rsp_valid[2] next cycle with er=1, coc=0, res=0.
- req[0..3] all held high with distinct operands (e.g. 30/5, 7/2, 0/10, 255/16) -> grants in order 0,1,2,3,0 and results 6r0, 3r1, 0r0, 15r15.
- Divider model never raises done -> after TIMEOUT=64 cycles in WAIT, rsp_valid[owner] with er=1, coc=res=0xFF; next request then serviced normally.
- RST asserted mid-WAIT -> all outputs 0 immediately (asynchronously), ptr=0. After release, pending req[3] and req[0] -> gnt[0] first.
- div_done held high from the previous op into the next ISSUE -> no premature response; completion only on the next done rising edge.
